// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks entries done on completion,
// and commits or flushes from the head.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH   = 16,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned PHY_ADDR_W  = 6,
    parameter int unsigned ARCH_ADDR_W = 5,
    localparam int unsigned IDX_W      = $clog2(ROB_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rob_incr_tail_ptr,
    input  logic [PC_WIDTH-1:0]    alloc_pc,
    input  logic [ARCH_ADDR_W-1:0] alloc_dest_arch,
    input  logic [PHY_ADDR_W-1:0]  alloc_dest_phy,
    input  logic [PHY_ADDR_W-1:0]  alloc_old_phy,
    input  logic                   alloc_has_dest,
    output logic [IDX_W-1:0]       rob_tail_ptr,
    output logic                   rob_full,
    output logic                   rob_empty,
    input  logic                   cmpl_en,
    input  logic [IDX_W-1:0]       cmpl_addr,
    input  logic                   cmpl_exception,
    output logic                   commit_valid,
    output logic [ARCH_ADDR_W-1:0] commit_dest_arch,
    output logic [PHY_ADDR_W-1:0]  commit_dest_phy,
    output logic [PHY_ADDR_W-1:0]  commit_old_phy,
    output logic                   commit_has_dest,
    output logic                   flush,
    output logic [PC_WIDTH-1:0]    pc_override
);

    localparam logic [IDX_W:0] PtrOne = 1;

    logic [IDX_W:0]          head_q, head_d;
    logic [IDX_W:0]          tail_q, tail_d;
    logic [ROB_DEPTH-1:0]    valid_q, valid_d;
    logic [ROB_DEPTH-1:0]    done_q, done_d;
    logic [ROB_DEPTH-1:0]    exc_q, exc_d;
    logic [PC_WIDTH-1:0]     pc_q        [ROB_DEPTH];
    logic [ARCH_ADDR_W-1:0]  dest_arch_q [ROB_DEPTH];
    logic [PHY_ADDR_W-1:0]   dest_phy_q  [ROB_DEPTH];
    logic [PHY_ADDR_W-1:0]   old_phy_q   [ROB_DEPTH];
    logic [ROB_DEPTH-1:0]    has_dest_q;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             alloc_ok;

    assign head_idx     = head_q[IDX_W-1:0];
    assign tail_idx     = tail_q[IDX_W-1:0];
    assign rob_tail_ptr = tail_idx;
    assign rob_empty    = (head_q == tail_q);
    assign rob_full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign alloc_ok     = rob_incr_tail_ptr && !rob_full;

    assign commit_valid     = valid_q[head_idx] && done_q[head_idx] && !exc_q[head_idx];
    assign flush            = valid_q[head_idx] && done_q[head_idx] && exc_q[head_idx];
    assign pc_override      = flush ? pc_q[head_idx] : '0;
    assign commit_dest_arch = dest_arch_q[head_idx];
    assign commit_dest_phy  = dest_phy_q[head_idx];
    assign commit_old_phy   = old_phy_q[head_idx];
    assign commit_has_dest  = has_dest_q[head_idx];

    // Order matters: completion, then commit, then allocation, so a fresh
    // allocation always leaves its entry with done/exc cleared.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end else begin
            if (cmpl_en && valid_q[cmpl_addr]) begin
                done_d[cmpl_addr] = 1'b1;
                exc_d[cmpl_addr]  = cmpl_exception;
            end
            if (commit_valid) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                exc_d[head_idx]   = 1'b0;
                head_d            = head_q + PtrOne;
            end
            if (alloc_ok) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                exc_d[tail_idx]   = 1'b0;
                tail_d            = tail_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (!rst && !flush && alloc_ok) begin
            pc_q[tail_idx]        <= alloc_pc;
            dest_arch_q[tail_idx] <= alloc_dest_arch;
            dest_phy_q[tail_idx]  <= alloc_dest_phy;
            old_phy_q[tail_idx]   <= alloc_old_phy;
            has_dest_q[tail_idx]  <= alloc_has_dest;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based ROB model predicts commits and
// flushes, and a negedge monitor checks them against the DUT.
module tb_reorder_buffer;

    localparam int D     = 16;
    localparam int PCW   = 32;
    localparam int PHYW  = 6;
    localparam int ARCHW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             rob_incr_tail_ptr;
    logic [PCW-1:0]   alloc_pc;
    logic [ARCHW-1:0] alloc_dest_arch;
    logic [PHYW-1:0]  alloc_dest_phy;
    logic [PHYW-1:0]  alloc_old_phy;
    logic             alloc_has_dest;
    logic [3:0]       rob_tail_ptr;
    logic             rob_full;
    logic             rob_empty;
    logic             cmpl_en;
    logic [3:0]       cmpl_addr;
    logic             cmpl_exception;
    logic             commit_valid;
    logic [ARCHW-1:0] commit_dest_arch;
    logic [PHYW-1:0]  commit_dest_phy;
    logic [PHYW-1:0]  commit_old_phy;
    logic             commit_has_dest;
    logic             flush;
    logic [PCW-1:0]   pc_override;

    reorder_buffer #(
        .ROB_DEPTH  (D),
        .PC_WIDTH   (PCW),
        .PHY_ADDR_W (PHYW),
        .ARCH_ADDR_W(ARCHW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rob_incr_tail_ptr(rob_incr_tail_ptr),
        .alloc_pc         (alloc_pc),
        .alloc_dest_arch  (alloc_dest_arch),
        .alloc_dest_phy   (alloc_dest_phy),
        .alloc_old_phy    (alloc_old_phy),
        .alloc_has_dest   (alloc_has_dest),
        .rob_tail_ptr     (rob_tail_ptr),
        .rob_full         (rob_full),
        .rob_empty        (rob_empty),
        .cmpl_en          (cmpl_en),
        .cmpl_addr        (cmpl_addr),
        .cmpl_exception   (cmpl_exception),
        .commit_valid     (commit_valid),
        .commit_dest_arch (commit_dest_arch),
        .commit_dest_phy  (commit_dest_phy),
        .commit_old_phy   (commit_old_phy),
        .commit_has_dest  (commit_has_dest),
        .flush            (flush),
        .pc_override      (pc_override)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCW-1:0]   pc;
        logic [ARCHW-1:0] arch;
        logic [PHYW-1:0]  phy;
        logic [PHYW-1:0]  old;
        logic             has;
        bit               done;
        bit               exc;
    } ent_t;

    typedef struct {
        bit               is_flush;
        logic [PCW-1:0]   pc;
        logic [ARCHW-1:0] arch;
        logic [PHYW-1:0]  phy;
        logic [PHYW-1:0]  old;
        logic             has;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    int   m_head = 0;
    int   m_tail = 0;
    int   vectors = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, check status, predict head behaviour, advance model.
    task automatic step(input logic r, input logic a, input logic [PCW-1:0] pc,
                        input logic c, input int caddr, input logic cexc);
        ent_t e;
        exp_t x;
        int   pre_size;
        int   k;
        bit   h_commit;
        bit   h_flush;
        rst               = r;
        rob_incr_tail_ptr = a;
        alloc_pc          = pc;
        alloc_dest_arch   = ARCHW'($urandom);
        alloc_dest_phy    = PHYW'($urandom);
        alloc_old_phy     = PHYW'($urandom);
        alloc_has_dest    = 1'($urandom);
        cmpl_en           = c;
        cmpl_addr         = 4'(caddr);
        cmpl_exception    = cexc;
        pre_size          = mq.size();
        check("empty", 64'(rob_empty), 64'(pre_size == 0));
        check("full", 64'(rob_full), 64'(pre_size == D));
        check("tail_ptr", 64'(rob_tail_ptr), 64'(m_tail % D));
        h_commit = (pre_size > 0) && mq[0].done && !mq[0].exc;
        h_flush  = (pre_size > 0) && mq[0].done && mq[0].exc;
        if (!r && (h_commit || h_flush)) begin
            x.is_flush = h_flush;
            x.pc       = mq[0].pc;
            x.arch     = mq[0].arch;
            x.phy      = mq[0].phy;
            x.old      = mq[0].old;
            x.has      = mq[0].has;
            exp_q.push_back(x);
        end
        @(posedge clk);
        if (r || h_flush) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            if (c) begin
                k = (caddr - (m_head % D) + D) % D;
                if (k < pre_size) begin
                    mq[k].done = 1'b1;
                    mq[k].exc  = cexc;
                end
            end
            if (h_commit) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % (2 * D);
            end
            if (a && pre_size < D) begin
                e.pc   = pc;
                e.arch = alloc_dest_arch;
                e.phy  = alloc_dest_phy;
                e.old  = alloc_old_phy;
                e.has  = alloc_has_dest;
                e.done = 1'b0;
                e.exc  = 1'b0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % (2 * D);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic alloc(input logic [PCW-1:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 0, 1'b0);
    endtask

    task automatic cmpl(input int idx, input logic ex);
        step(1'b0, 1'b0, '0, 1'b1, idx, ex);
    endtask

    // Monitor: every DUT commit or flush must match the oldest prediction.
    always @(negedge clk) begin
        exp_t x;
        if (rst === 1'b0) begin
            if (!flush) check("pc_override_idle", 64'(pc_override), 64'd0);
            if (commit_valid && flush) check("commit_and_flush", 64'd1, 64'd0);
            if (commit_valid || flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", {32'd0, pc_override}, 64'hdead);
                end else begin
                    x = exp_q.pop_front();
                    check("retire_kind", 64'(flush), 64'(x.is_flush));
                    if (x.is_flush) begin
                        check("pc_override", 64'(pc_override), 64'(x.pc));
                    end else begin
                        check("commit_arch", 64'(commit_dest_arch), 64'(x.arch));
                        check("commit_phy", 64'(commit_dest_phy), 64'(x.phy));
                        check("commit_old", 64'(commit_old_phy), 64'(x.old));
                        check("commit_has", 64'(commit_has_dest), 64'(x.has));
                    end
                end
            end
        end
    end

    initial begin
        int ci;
        rst = 1'b1; rob_incr_tail_ptr = 1'b0; alloc_pc = '0; alloc_dest_arch = '0;
        alloc_dest_phy = '0; alloc_old_phy = '0; alloc_has_dest = 1'b0;
        cmpl_en = 1'b0; cmpl_addr = '0; cmpl_exception = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        check("reset_commit_valid", 64'(commit_valid), 64'd0);
        check("reset_flush", 64'(flush), 64'd0);

        // Three allocations, out-of-order completion, in-order commit
        alloc(32'h0); alloc(32'h4); alloc(32'h8);
        idle(1);
        cmpl(2, 1'b0); cmpl(0, 1'b0); cmpl(1, 1'b0);
        idle(4);

        // Fill to full, reject overflow, commit with rejected simultaneous allocation
        step(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        for (int i = 0; i < D; i++) alloc(PCW'(32'h200 + 4 * i));
        idle(1);
        alloc(32'hbad0);
        cmpl(0, 1'b0);
        step(1'b0, 1'b1, 32'hbad4, 1'b0, 0, 1'b0);
        idle(1);
        for (int i = 1; i < D; i++) cmpl(i, 1'b0);
        idle(3);

        // Exception behind a normal commit triggers flush
        step(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) alloc(PCW'(32'h100 + 4 * i));
        cmpl(1, 1'b1); cmpl(0, 1'b0);
        idle(3);

        // Reset mid-operation with a completion pending
        for (int i = 0; i < 5; i++) alloc(PCW'(32'h300 + 4 * i));
        cmpl(2, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 0, 1'b0);
        idle(1);
        check("post_reset_commit", 64'(commit_valid), 64'd0);

        // Streaming allocate/complete across several pointer wraps
        for (int i = 0; i < 40; i++) begin
            ci = (m_tail + 2 * D - 1) % D;
            step(1'b0, 1'b1, PCW'(32'h1000 + 4 * i), 1'b1, ci, 1'b0);
        end
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                ci = ((m_head % D) + $urandom_range(0, mq.size() - 1)) % D;
            else
                ci = $urandom_range(0, D - 1);
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0), PCW'($urandom),
                 1'($urandom_range(0, 1)), ci, 1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < D; i++) cmpl(i, 1'b0);
        idle(D + 4);
        @(negedge clk);
        check("pending_predictions", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
